// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
// Exports XLEN/ILEN, NOP_INSTR, the fetch_entry_t bundle and cnt_width().
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Counters that must hold the value DEPTH itself need one extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t, DEPTH entries (power of 2).
// Ports: clk, rst, push/pop/clear, wdata, rdata (head, 0 when empty), full, empty, count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Push into a full FIFO only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end; PC, imem request/credit control, prefetch FIFO to decode.
// Ports: clk, rst (sync, high), redirect_*, imem_req_*, imem_resp_*, out_*; FETCH_PERF_CNT_EN adds perf_*.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus_4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_stall,
    output logic [31:0] perf_redirects
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] buf_count;
    logic [CW:0]   inflight;
    logic          req_fire;
    logic          resp_live;
    logic          buf_pop;
    logic          buf_empty;

    fetch_entry_t  tag_in;
    fetch_entry_t  tag_head;
    fetch_entry_t  buf_in;
    fetch_entry_t  buf_head;
    logic [31:0]   tag_pc;

    logic [31:0]   tag_instr_unused;
    logic [CW-1:0] tag_count_unused;
    logic          tag_full_unused;
    logic          tag_empty_unused;
    logic          buf_full_unused;
    logic [1:0]    redirect_pc_lo_unused;

    assign redirect_pc_lo_unused = redirect_pc[1:0];

    // Buffered plus in-flight (live and to-be-dropped) never exceeds DEPTH.
    assign inflight = {1'b0, buf_count} + {1'b0, outstanding};

    assign imem_req_valid = !rst && !redirect_valid && (inflight < CAP);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_live = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;

    // The tag queue only ever holds PCs of live requests; it is flushed
    // with the prefetch buffer and popped by live responses only.
    assign tag_in = '{instr: '0, pc: pc};
    assign {tag_instr_unused, tag_pc} = tag_head;

    fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (resp_live),
        .clear (redirect_valid),
        .wdata (tag_in),
        .rdata (tag_head),
        .full  (tag_full_unused),
        .empty (tag_empty_unused),
        .count (tag_count_unused)
    );

    assign buf_in  = '{instr: imem_resp_data, pc: tag_pc};
    assign buf_pop = out_valid && out_ready && !redirect_valid;

    fetch_fifo #(.DEPTH(DEPTH)) u_prefetch (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live),
        .pop   (buf_pop),
        .clear (redirect_valid),
        .wdata (buf_in),
        .rdata (buf_head),
        .full  (buf_full_unused),
        .empty (buf_empty),
        .count (buf_count)
    );

    assign out_valid     = !rst && !buf_empty;
    assign out_instr     = buf_head.instr;
    assign out_pc        = buf_head.pc;
    assign out_pc_plus_4 = buf_empty ? '0 : buf_head.pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            unique case (1'b1)
                redirect_valid: pc <= {redirect_pc[31:2], 2'b00};
                req_fire:       pc <= pc + 32'd4;
                default:        pc <= pc;
            endcase
            // A response arriving with the redirect is itself discarded.
            if (redirect_valid)
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            else if (imem_resp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_stall <= '0;
            perf_redirects   <= '0;
        end else begin
            if (!out_valid && !redirect_valid && perf_fetch_stall != '1)
                perf_fetch_stall <= perf_fetch_stall + 32'd1;
            if (redirect_valid && perf_redirects != '1)
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a queue-based memory and stream model.
// Model checks every cycle; literal expectations pin the directed scenarios.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus_4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_stall;
    logic [31:0] perf_redirects;
    logic [31:0] m_stall = '0;
    logic [31:0] m_redir = '0;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .out_pc_plus_4   (out_pc_plus_4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_stall(perf_fetch_stall),
        .perf_redirects  (perf_redirects)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        mq[$];
    ent_t        mbuf[$];
    logic [31:0] popped[$];
    logic [31:0] popped4[$];
    logic [31:0] m_pc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_req = 0;
    int          ntests = 0;
    int          nfail = 0;
    logic        last_req_valid;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] pk(input int i);
        return (i < popped.size()) ? popped[i] : 32'hBAD0_BAD0;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic check();
        logic exp_rv;
        logic exp_ov;
        if (rst) begin
            chk("req_valid_in_rst", imem_req_valid, 0);
            chk("out_valid_in_rst", out_valid, 0);
        end else begin
            exp_rv = !redirect_valid && (mbuf.size() + mq.size() < DEPTH);
            chk("req_valid", imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
            exp_ov = (mbuf.size() != 0);
            chk("out_valid", out_valid, exp_ov);
            if (exp_ov) begin
                chk("out_pc", out_pc, mbuf[0].pc);
                chk("out_instr", out_instr, mbuf[0].instr);
                chk("out_pc_plus_4", out_pc_plus_4, mbuf[0].pc + 32'd4);
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetch_stall", perf_fetch_stall, m_stall);
        chk("perf_redirects", perf_redirects, m_redir);
`endif
    endtask

    task automatic update();
        logic fire;
        logic stalled;
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        if (rst) begin
            mq.delete();
            mbuf.delete();
            m_pc = RESET_PC;
            epoch++;
`ifdef FETCH_PERF_CNT_EN
            m_stall = '0;
            m_redir = '0;
`endif
            return;
        end
        stalled = (mbuf.size() == 0) && !redirect_valid;
`ifdef FETCH_PERF_CNT_EN
        if (stalled && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect_valid && m_redir != 32'hFFFF_FFFF) m_redir++;
`endif
        fire = imem_req_valid && imem_req_ready;
        if (fire) n_req++;
        if (mbuf.size() != 0 && out_ready && !redirect_valid) begin
            popped.push_back(out_pc);
            popped4.push_back(out_pc_plus_4);
            void'(mbuf.pop_front());
        end
        if (imem_resp_valid && mq.size() != 0) begin
            req_t r;
            r = mq.pop_front();
            if (!redirect_valid && r.epoch == epoch)
                mbuf.push_back('{r.addr, word_at(r.addr)});
        end
        if (fire) mq.push_back('{m_pc, epoch, cyc + lat});
        if (redirect_valid) begin
            mbuf.delete();
            epoch++;
            m_pc = {redirect_pc[31:2], 2'b00};
        end else if (fire) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic drive_mem();
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_at(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check();
        update();
        @(posedge clk);
        #1;
        cyc++;
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit hit;

        // Streaming, 1-cycle memory, decode always ready.
        lat = 1;
        do_reset();
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        popped.delete();
        tick();
        chk("s1_first_req_valid", last_req_valid, 1);
        chk("s1_first_req_addr", last_req_addr, 32'h0);
        repeat (8) tick();
        chk("s1_pop0", pk(0), 32'h0);
        chk("s1_pop1", pk(1), 32'h4);
        chk("s1_pop2", pk(2), 32'h8);

        // Credit cap with decode stalled.
        do_reset();
        imem_req_ready = 1'b1;
        n_req = 0;
        repeat (12) tick();
        chk("s2_cap_reqs", n_req, 4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_req = 0;
        repeat (10) tick();
        chk("s2_one_more_req", n_req, 1);

        // Redirect with two requests in flight, 3-cycle memory.
        lat = 3;
        do_reset();
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        popped.delete();
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        chk("s3_drop_cnt", dut.drop_cnt, 2);
        repeat (12) tick();
        chk("s3_pop0", pk(0), 32'h100);
        chk("s3_pop1", pk(1), 32'h104);

        // Redirect coinciding with a response, 2-cycle memory.
        lat = 2;
        do_reset();
        out_ready = 1'b1;
        imem_req_ready = 1'b1;
        repeat (6) tick();
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            if (imem_resp_valid) hit = 1'b1;
            else tick();
        end
        chk("s4_resp_seen", hit, 1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        popped.delete();
        tick();
        redirect_valid = 1'b0;
        chk("s4_fifo_empty", out_valid, 0);
        chk("s4_drop_model", dut.drop_cnt, stale_count());
        chk("s4_drop_lit", dut.drop_cnt, 1);
        repeat (10) tick();
        chk("s4_pop0", pk(0), 32'h40);

        // Alignment of the redirect target and PC wrap-around.
        lat = 1;
        do_reset();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        chk("s5_aligned_addr", last_req_addr, 32'h200);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        popped.delete();
        popped4.delete();
        tick();
        tick();
        chk("s5_wrap_req_addr", last_req_addr, 32'h0);
        repeat (6) tick();
        chk("s5_pop0", pk(0), 32'hFFFF_FFFC);
        chk("s5_pop1", pk(1), 32'h0);
        chk("s5_pc4_wrap", (popped4.size() != 0) ? popped4[0] : 32'hBAD0_BAD0, 32'h0);

        // Reset in the middle of a stream with three buffered entries.
        do_reset();
        imem_req_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (mbuf.size() == 3) hit = 1'b1;
            else tick();
        end
        chk("s6_three_buffered", hit, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_out_valid", out_valid, 0);
        chk("s6_reset_pc", imem_req_addr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        chk("s6_perf_stall", perf_fetch_stall, 0);
        chk("s6_perf_redir", perf_redirects, 0);
`endif
        repeat (6) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
